// File: rtl/setbit_enum.sv
// ============================================================================
// Module   : setbit_enum
// Purpose  : Expands a bit mask into a stream of set-bit indices, one index
//            per output beat, with valid/ready handshakes on both sides.
//            A zero mask produces a single beat flagged OutEmpty.
// Options  : SETBIT_ENUM_REVERSE_EN - when defined, enumerate MSB-first;
//            otherwise enumerate LSB-first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module setbit_enum #(
    parameter int WIDTH = 32,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              InValid,
    output logic              InReady,
    input  logic [WIDTH-1:0]  InMask,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [IDXW-1:0]   OutIdx,
    output logic [IDXW:0]     OutOrd,
    output logic              OutLast,
    output logic              OutEmpty
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_ZERO = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] rem;        // bits still to be enumerated
    logic [IDXW:0]    ord;        // ordinal of the beat currently offered
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_empty_q;

    logic [IDXW-1:0]  enc_idx;
    logic             rem_single;
    logic [WIDTH-1:0] rem_cleared;

    // Priority encoder: picks the next bit to emit from the remaining mask.
    always_comb begin
        enc_idx = '0;
`ifdef SETBIT_ENUM_REVERSE_EN
        // Ascending scan, so the highest set bit is the last one written.
        for (int i = 0; i < WIDTH; i++) begin
            if (rem[i]) enc_idx = i[IDXW-1:0];
        end
`else
        // Descending scan, so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rem[i]) enc_idx = i[IDXW-1:0];
        end
`endif
    end

    // Exactly-one-bit test and the remaining mask after the current beat.
    assign rem_single  = (rem != '0) && ((rem & (rem - C_ONE)) == '0);
    assign rem_cleared = rem & ~(C_ONE << enc_idx);

    // Control FSM: accepts a mask, walks it beat by beat, then returns to idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            rem         <= '0;
            ord         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_empty_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (InValid) begin
                        rem         <= InMask;
                        ord         <= '0;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        if (InMask == '0) begin
                            state       <= S_ZERO;
                            out_empty_q <= 1'b1;
                        end else begin
                            state       <= S_EMIT;
                            out_empty_q <= 1'b0;
                        end
                    end
                end
                S_EMIT: begin
                    if (OutReady) begin
                        rem <= rem_cleared;
                        ord <= ord + 1'b1;
                        if (rem_single) begin
                            state       <= S_IDLE;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                S_ZERO: begin
                    if (OutReady) begin
                        state       <= S_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_empty_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    rem         <= '0;
                    ord         <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_empty_q <= 1'b0;
                end
            endcase
        end
    end

    // Beat fields are only meaningful in EMIT; ZERO and IDLE present zeros.
    assign InReady  = in_ready_q;
    assign OutValid = out_valid_q;
    assign OutEmpty = out_empty_q;
    assign OutIdx   = (state == S_EMIT) ? enc_idx : '0;
    assign OutOrd   = (state == S_EMIT) ? ord : '0;
    assign OutLast  = (state == S_EMIT) ? rem_single : (state == S_ZERO);

endmodule

`default_nettype wire

// File: tb/tb_setbit_enum.sv
// ============================================================================
// Module   : tb_setbit_enum
// Purpose  : Self-checking bench for setbit_enum (WIDTH=32) using a
//            scoreboard of expected beats built from a reference expansion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_setbit_enum;

    localparam int WIDTH = 32;
    localparam int IDXW  = 5;

    typedef struct {
        int idx;
        int ord;
        bit last;
        bit empty;
    } beat_t;

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_mask;
    logic              out_valid;
    logic              out_ready;
    logic [IDXW-1:0]   out_idx;
    logic [IDXW:0]     out_ord;
    logic              out_last;
    logic              out_empty;

    int    tests;
    int    fails;
    beat_t q[$];

    setbit_enum #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .InMask   (in_mask),
        .OutValid (out_valid),
        .OutReady (out_ready),
        .OutIdx   (out_idx),
        .OutOrd   (out_ord),
        .OutLast  (out_last),
        .OutEmpty (out_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference expansion of a mask into the beats it must produce.
    task automatic push_expected(input logic [WIDTH-1:0] m);
        int    pop;
        int    n;
        beat_t b;
        pop = $countones(m);
        if (pop == 0) begin
            b.idx = 0; b.ord = 0; b.last = 1'b1; b.empty = 1'b1;
            q.push_back(b);
        end else begin
            n = 0;
            for (int k = 0; k < WIDTH; k++) begin
`ifdef SETBIT_ENUM_REVERSE_EN
                int pos = WIDTH - 1 - k;
`else
                int pos = k;
`endif
                if (m[pos]) begin
                    b.idx = pos; b.ord = n; b.last = (n == pop - 1); b.empty = 1'b0;
                    q.push_back(b);
                    n++;
                end
            end
        end
    endtask

    // Compares the offered beat against the scoreboard head; pops on handshake.
    task automatic check_beat(input string tag);
        beat_t e;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = q[0];
            check({tag, "_idx"},   64'(out_idx),   64'(e.idx));
            check({tag, "_ord"},   64'(out_ord),   64'(e.ord));
            check({tag, "_last"},  64'(out_last),  64'(e.last));
            check({tag, "_empty"}, 64'(out_empty), 64'(e.empty));
            if (out_ready) void'(q.pop_front());
        end
    endtask

    // Full transaction: offer a mask, drain its beats, confirm return to idle.
    // mode 0: OutReady always high; mode 1: OutReady toggles every cycle.
    task automatic run_mask(input string tag, input logic [WIDTH-1:0] m, input int mode);
        int n;
        push_expected(m);
        in_valid  = 1'b1;
        in_mask   = m;
        out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_mask  = ~m;                 // must not be re-sampled
        n = 0;
        while (q.size() > 0 && n < 200) begin
            out_ready = (mode == 0) ? 1'b1 : n[0];
            @(negedge clk);
            check_beat(tag);
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_drained"}, 64'(q.size()), 64'd0);
        q.delete();
        @(negedge clk);
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_mask   = 32'h0000_0005;
        out_ready = 1'b1;

        // Reset held with InValid asserted: no accept, outputs at reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_idx",       64'(out_idx),   64'd0);
        check("rst_ord",       64'(out_ord),   64'd0);
        check("rst_last",      64'(out_last),  64'd0);
        check("rst_empty",     64'(out_empty), 64'd0);
        @(posedge clk); #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // Directed masks.
        run_mask("m80000011", 32'h8000_0011, 0);
        run_mask("zero",      32'h0000_0000, 0);
        run_mask("ones_stall", 32'hFFFF_FFFF, 1);
        run_mask("a5",        32'h0000_00A5, 1);

        // Back-to-back masks 1 then 2 with InValid held high.
        push_expected(32'h1);
        push_expected(32'h2);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mask   = 32'h1;
        @(negedge clk);
        check("b2b_accept1", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_mask = 32'h2;
        @(negedge clk);
        check("b2b_busy", 64'(in_ready), 64'd0);
        check_beat("b2b_beat1");
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_gap_valid", 64'(out_valid), 64'd0);
        check("b2b_gap_ready", 64'(in_ready),  64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_beat("b2b_beat2");
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_end_valid", 64'(out_valid), 64'd0);
        check("b2b_sb", 64'(q.size()), 64'd0);
        q.delete();
        @(posedge clk); #1;

        // Reset asserted mid-enumeration of 0xF0 after two beats.
        push_expected(32'h0000_00F0);
        in_valid = 1'b1;
        in_mask  = 32'h0000_00F0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_beat("mid");
            @(posedge clk); #1;
        end
        q.delete();
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready),  64'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("mid_after_valid", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end

        // Enumeration resumes normally after the reset.
        run_mask("after_rst", 32'h0000_0300, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
